if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode and the immediate extender.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Presents {instr, pc, pc+4} to decode with a valid/ready handshake.
- Handles redirects from execute: taken branch/jump discards in-flight and buffered fetches.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/if_skid_buf.sv | 56 +++++
 rtl/if_stage.sv | 181 ++++++++++++++++++
 tb/tb_if_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the instruction-fetch stage.
//   NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0), used for bubbles
//   DEFAULT_RESET_PC : default PC loaded on reset
//   fetch_state_t    : fetch FSM states
//   if_id_t          : payload carried by the skid buffer and IF/ID register
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;
  } if_id_t;

  // Sequential PC, wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// -----------------------------------------------------------------------------
// if_skid_buf
// One-entry holding buffer for a fetched instruction that arrived while the
// IF/ID register was stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : discard contents (wins over push/pop)
//   push_i     : write data_i, buffer becomes full
//   pop_i      : release current entry (push in the same cycle refills it)
//   data_i     : entry to store
//   data_o     : stored entry
//   full_o     : buffer holds a valid entry
// -----------------------------------------------------------------------------
module if_skid_buf
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  if_id_t data_i,
  output if_id_t data_o,
  output logic   full_o
);

  logic   full_q, full_d;
  if_id_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else begin
      if (pop_i) full_d = 1'b0;
      if (push_i) begin
        full_d = 1'b1;
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage with IF/ID pipeline register. Owns the PC, issues
// one word fetch at a time to instruction memory and hands {instr, pc, pc+4}
// to decode. Redirects from execute flush buffered/in-flight fetches.
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_req_*      : fetch request channel (valid/ready, word address)
//   imem_rsp_*      : in-order fetch response (valid, instruction word)
//   redirect_*      : control-flow redirect from execute
//   id_valid/ready  : IF/ID handshake with decode
//   id_instr/pc/... : IF/ID payload; id_misaligned flags a misaligned target
// -----------------------------------------------------------------------------
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_misaligned
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         halt_q, halt_d;      // misaligned target: stop fetching
  logic         started_q;           // keeps requests low until first edge after reset
  logic         id_valid_q, id_valid_d;
  if_id_t       id_q, id_d;
  logic [31:0]  id_pc4_q, id_pc4_d;

  logic   skid_full, skid_push, skid_pop, skid_flush;
  if_id_t skid_data, rsp_entry;
  logic   req_fire, rsp_take, id_free, redirect_mis;

  assign req_fire     = imem_req_valid && imem_req_ready;
  assign rsp_take     = imem_rsp_valid && (state_q == WAIT) && !drop_q;
  assign id_free      = !id_valid_q || id_ready;
  assign redirect_mis = |redirect_pc[1:0];

  // Only one request is ever outstanding, so the returning word belongs to
  // the address just before the (already advanced) PC.
  always_comb begin
    rsp_entry            = '0;
    rsp_entry.instr      = imem_rsp_data;
    rsp_entry.pc         = pc_q - 32'd4;
    rsp_entry.misaligned = 1'b0;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (req_fire) state_d = WAIT;
      WAIT:    if (imem_rsp_valid) state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (redirect_valid) state_d = FETCH;
  end

  // ---------------- FSM: outputs ----------------
  // Requests are held off while the skid is full (nowhere to land a
  // response), while a stale response is still owed (drop), and after a
  // misaligned redirect.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_q;
    if (state_q == FETCH)
      imem_req_valid = started_q && !skid_full && !drop_q && !halt_q;
  end

  // ---------------- PC, drop flag, IF/ID and skid control ----------------
  always_comb begin
    pc_d       = pc_q;
    drop_d     = drop_q;
    halt_d     = halt_q;
    id_valid_d = id_valid_q;
    id_d       = id_q;
    id_pc4_d   = id_pc4_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_flush = 1'b0;

    if (redirect_valid) begin
      skid_flush = 1'b1;
      pc_d       = {redirect_pc[31:2], 2'b00};
      // A fetch still owed by memory (or issued this very cycle) must be
      // swallowed; one returning right now is simply ignored.
      drop_d     = (((state_q == WAIT) || drop_q) && !imem_rsp_valid) || req_fire;
      halt_d     = redirect_mis;
      id_valid_d = redirect_mis;
      if (redirect_mis) begin
        id_d.instr      = NOP_INSTR;
        id_d.pc         = redirect_pc;
        id_d.misaligned = 1'b1;
        id_pc4_d        = pc_plus4(redirect_pc);
      end
    end else begin
      if (req_fire) pc_d = pc_plus4(pc_q);
      if (drop_q && imem_rsp_valid) drop_d = 1'b0;

      if (id_free) begin
        if (skid_full) begin
          // Older buffered entry goes first.
          skid_pop   = 1'b1;
          skid_push  = rsp_take;
          id_valid_d = 1'b1;
          id_d       = skid_data;
          id_pc4_d   = pc_plus4(skid_data.pc);
        end else if (rsp_take) begin
          id_valid_d = 1'b1;
          id_d       = rsp_entry;
          id_pc4_d   = pc_plus4(rsp_entry.pc);
        end else begin
          id_valid_d = 1'b0;
        end
      end else begin
        skid_push = rsp_take;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      drop_q          <= 1'b0;
      halt_q          <= 1'b0;
      started_q       <= 1'b0;
      id_valid_q      <= 1'b0;
      id_q.instr      <= NOP_INSTR;
      id_q.pc         <= '0;
      id_q.misaligned <= 1'b0;
      id_pc4_q        <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      halt_q     <= halt_d;
      started_q  <= 1'b1;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
      id_pc4_q   <= id_pc4_d;
    end
  end

  if_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (skid_flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (rsp_entry),
    .data_o  (skid_data),
    .full_o  (skid_full)
  );

  // A bubble always presents a NOP with no misalignment flag.
  assign id_valid      = id_valid_q;
  assign id_instr      = id_valid_q ? id_q.instr : NOP_INSTR;
  assign id_pc         = id_q.pc;
  assign id_pc_plus4   = id_pc4_q;
  assign id_misaligned = id_valid_q && id_q.misaligned;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage with a small instruction-memory responder.
// Memory returns ~addr as the instruction word after a programmable latency.
// -----------------------------------------------------------------------------
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        id_misaligned;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_misaligned  (id_misaligned)
  );

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int cyc    = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        mis;
    int          cyc;
  } id_rec_t;

  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  id_rec_t     id_log[$];

  // ---------------- memory responder ----------------
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pend       <= 1'b0;
      mem_addr       <= '0;
      mem_cnt        <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= ~mem_addr;
          mem_pend       <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        if (lat <= 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= ~imem_req_addr;
        end else begin
          mem_pend <= 1'b1;
          mem_addr <= imem_req_addr;
          mem_cnt  <= lat - 1;
        end
      end
    end
  end

  // ---------------- transaction logger ----------------
  always @(posedge clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      if (imem_req_valid && imem_req_ready) begin
        acc_log.push_back(imem_req_addr);
        acc_cyc.push_back(cyc);
        $display("[%0t] req  addr=%h", $time, imem_req_addr);
      end
      if (id_valid && id_ready) begin
        id_log.push_back('{pc: id_pc, instr: id_instr, pc4: id_pc_plus4, mis: id_misaligned, cyc: cyc});
        $display("[%0t] id   pc=%h instr=%h pc4=%h mis=%0b", $time, id_pc, id_instr, id_pc_plus4, id_misaligned);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
    id_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_id(input int n, input int budget, input string tag);
    int b;
    b = budget;
    while (id_log.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    checks++;
    assert (id_log.size() >= n) else begin
      errors++;
      $error("FAIL %s: timeout, observed id count=%0d expected>=%0d", tag, id_log.size(), n);
    end
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int b;
    b = budget;
    while (acc_log.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    checks++;
    assert (acc_log.size() >= n) else begin
      errors++;
      $error("FAIL %s: timeout, observed req count=%0d expected>=%0d", tag, acc_log.size(), n);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b;
    logic [31:0] hold_pc, hold_instr;

    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    lat            = 1;

    // Reset state
    #1;
    chk("rst_id_valid",  {31'b0, id_valid}, 32'd0);
    chk("rst_id_instr",  id_instr, 32'h0000_0013);
    chk("rst_id_pc",     id_pc, 32'h0);
    chk("rst_id_pc4",    id_pc_plus4, 32'h0);
    chk("rst_id_mis",    {31'b0, id_misaligned}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid", {31'b0, imem_req_valid}, 32'd0);

    // Streaming with 1-cycle memory
    wait_id(3, 30, "p1_wait");
    chk("p1_addr0", acc_log[0], 32'h0000_0100);
    chk("p1_addr1", acc_log[1], 32'h0000_0104);
    chk("p1_addr2", acc_log[2], 32'h0000_0108);
    chk("p1_gap01", acc_cyc[1] - acc_cyc[0], 32'd2);
    chk("p1_gap12", acc_cyc[2] - acc_cyc[1], 32'd2);
    chk("p1_pc0",   id_log[0].pc, 32'h0000_0100);
    chk("p1_pc1",   id_log[1].pc, 32'h0000_0104);
    chk("p1_pc2",   id_log[2].pc, 32'h0000_0108);
    chk("p1_pc4_0", id_log[0].pc4, 32'h0000_0104);
    chk("p1_pc4_2", id_log[2].pc4, 32'h0000_010C);
    chk("p1_ins0",  id_log[0].instr, 32'hFFFF_FEFF);
    chk("p1_ins1",  id_log[1].instr, 32'hFFFF_FEFB);

    // Decode stall: IF/ID holds, second word lands in skid, no third request
    id_ready = 1'b0;
    do_reset();
    b = 20;
    while (!id_valid && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("p2_valid", {31'b0, id_valid}, 32'd1);
    chk("p2_pc",    id_pc, 32'h0000_0100);
    hold_pc    = id_pc;
    hold_instr = id_instr;
    for (int k = 0; k < 5; k++) begin
      chk("p2_hold_valid", {31'b0, id_valid}, 32'd1);
      chk("p2_hold_pc",    id_pc, hold_pc);
      chk("p2_hold_instr", id_instr, hold_instr);
      @(negedge clk);
    end
    chk("p2_skid_full", {31'b0, dut.u_skid.full_o}, 32'd1);
    chk("p2_req_count", acc_log.size(), 32'd2);
    id_ready = 1'b1;
    wait_id(2, 20, "p2_release");
    chk("p2_id0_pc", id_log[0].pc, 32'h0000_0100);
    chk("p2_id1_pc", id_log[1].pc, 32'h0000_0104);
    chk("p2_id_gap", id_log[1].cyc - id_log[0].cyc, 32'd1);

    // 3-cycle memory, redirect one cycle after an accept
    lat = 3;
    do_reset();
    b = 20;
    while (!imem_req_valid && b > 0) begin
      @(negedge clk);
      b--;
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_id(1, 40, "p3_wait");
    chk("p3_id_pc",    id_log[0].pc, 32'h0000_0200);
    chk("p3_id_instr", id_log[0].instr, 32'hFFFF_FDFF);
    chk("p3_addr0",    acc_log[0], 32'h0000_0100);
    chk("p3_addr1",    acc_log[1], 32'h0000_0200);

    // Misaligned redirect
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("p4_valid", {31'b0, id_valid}, 32'd1);
    chk("p4_mis",   {31'b0, id_misaligned}, 32'd1);
    chk("p4_instr", id_instr, 32'h0000_0013);
    chk("p4_pc",    id_pc, 32'h0000_0202);
    chk("p4_pc4",   id_pc_plus4, 32'h0000_0206);
    clear_logs();
    repeat (10) @(negedge clk);
    chk("p4_no_req",    acc_log.size(), 32'd0);
    chk("p4_req_low",   {31'b0, imem_req_valid}, 32'd0);
    chk("p4_id_count",  id_log.size(), 32'd1);
    chk("p4_bubble",    {31'b0, id_valid}, 32'd0);
    chk("p4_bub_mis",   {31'b0, id_misaligned}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    clear_logs();
    wait_id(1, 20, "p4_resume");
    chk("p4_res_addr",  acc_log[0], 32'h0000_0300);
    chk("p4_res_pc",    id_log[0].pc, 32'h0000_0300);
    chk("p4_res_instr", id_log[0].instr, 32'hFFFF_FCFF);
    chk("p4_res_mis",   {31'b0, id_log[0].mis}, 32'd0);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    clear_logs();
    wait_id(2, 30, "p5_wait");
    chk("p5_addr0",  acc_log[0], 32'hFFFF_FFFC);
    chk("p5_addr1",  acc_log[1], 32'h0000_0000);
    chk("p5_pc0",    id_log[0].pc, 32'hFFFF_FFFC);
    chk("p5_pc4_0",  id_log[0].pc4, 32'h0000_0000);
    chk("p5_instr0", id_log[0].instr, 32'h0000_0003);
    chk("p5_pc1",    id_log[1].pc, 32'h0000_0000);

    // Asynchronous reset while waiting on memory with IF/ID occupied
    id_ready = 1'b0;
    lat      = 3;
    b = 30;
    while (!(id_valid && dut.state_q == riscv_pkg::WAIT) && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("p6_in_wait", (id_valid && dut.state_q == riscv_pkg::WAIT) ? 32'd1 : 32'd0, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("p6_valid", {31'b0, id_valid}, 32'd0);
    chk("p6_instr", id_instr, 32'h0000_0013);
    chk("p6_req",   {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    clear_logs();
    lat      = 1;
    id_ready = 1'b1;
    rst_n    = 1'b1;
    wait_acc(1, 20, "p6_refetch");
    chk("p6_addr0", acc_log[0], 32'h0000_0100);
    wait_id(1, 20, "p6_id");
    chk("p6_id_pc", id_log[0].pc, 32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
